axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
Two-requester AXI4 read-channel arbiter placed between AXI read masters and the single AR/R port of axi_ddr3_lite. Examples of masters are axis_ddr3_ctrl and a future DMA/video reader.
- AR requests are granted round-robin and forwarded through one output register.
- The port index is appended as the outgoing ID MSB.
- R beats are routed back by that ID bit.
- Per-port outstanding-burst counters bound the number of in-flight reads.

Parameters:
ADDRS, 27, AXI byte-address width
WIDTH, 32, read data width
REQID, 4, requester ID width (memory-side ID is REQID+1)
MAX_PENDING, 4, max outstanding bursts per requester (1..15)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
sN_arvalid_i  in  1  requester N AR valid (N = 0,1; all sN_ ports are replicated per requester)
sN_arready_o  out  1  requester N AR ready
sN_araddr_i  in  ADDRS  AR address
sN_arid_i  in  REQID  AR ID
sN_arlen_i  in  8  AR burst length
sN_arburst_i  in  2  AR burst type
sN_rvalid_o  out  1  R valid
sN_rready_i  in  1  R ready
sN_rlast_o  out  1  R last
sN_rresp_o  out  2  R response
sN_rid_o  out  REQID  R ID (index bit stripped)
sN_rdata_o  out  WIDTH  R data
m_arvalid_o  out  1  to controller: AR valid
m_arready_i  in  1  from controller: AR ready
m_araddr_o  out  ADDRS  AR address
m_arid_o  out  REQID+1  {port index, sN_arid}
m_arlen_o  out  8  AR burst length
m_arburst_o  out  2  AR burst type
m_rvalid_i  in  1  from controller: R valid
m_rready_o  out  1  to controller: R ready
m_rlast_i  in  1  R last
m_rresp_i  in  2  R response
m_rid_i  in  REQID+1  R ID
m_rdata_i  in  WIDTH  R data
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, release synchronous to clock):
  - FSM = IDLE; m_arvalid_o = 0; m_ar* payload = 0.
  - Round-robin pointer = 0 (requester 0 has priority).
  - Both pending counters = 0; err_o = 0.
- Eligibility: requester N is eligible when sN_arvalid_i=1 and pendN < MAX_PENDING.
- FSM IDLE:
  - grant = the eligible requester, with the pointer's requester preferred.
  - sN_arready_o = 1 combinationally, only for the granted requester.
  - On that cycle's edge: latch its payload into the m_ar* registers, set m_arid_o = {N, sN_arid_i}, set m_arvalid_o = 1, increment pendN, pointer = ~N, go to HOLD.
  - If nothing is eligible, stay in IDLE.
- FSM HOLD:
  - Both sN_arready_o = 0; payload is held stable.
  - On m_arvalid_o & m_arready_i: clear m_arvalid_o and go to IDLE.
  - Latency: AR is accepted at edge k; m_arvalid_o is high from k+1. Peak rate is one AR per 2 cycles.
- Pending counters:
  - Width is clog2(MAX_PENDING+1).
  - Decrement on m_rvalid_i & m_rready_o & m_rlast_i for port m_rid_i[REQID].
  - Increment and decrement on the same port in the same cycle leaves the count unchanged.
  - A counter never wraps: decrement at 0 is suppressed, increment is blocked by eligibility.
- R path, purely combinational, zero latency:
  - sel = m_rid_i[REQID].
  - sN_rvalid_o = m_rvalid_i & (sel==N).
  - m_rready_o = s{sel}_rready_i.
  - rlast, rresp and rdata fan out to both ports; sN_rid_o = m_rid_i[REQID-1:0].
  - Each burst's beats are forwarded in controller order; the arbiter never reorders.
- Reset mid-burst:
  - Counters clear and any pending AR in the output register is dropped (m_arvalid_o = 0).
  - R beats still arriving are routed by ID; counter decrement at 0 is suppressed.

Optional Feature:
AXI_RD_ARB_CHECK_EN
- Defined: err_o sets and stays set until reset when either event occurs:
  - An R beat is accepted for a port whose pending counter is 0.
  - m_arlen_i-independent rresp != 2'b00 is seen on any accepted beat.
- Not defined: err_o is tied to 0 and no check logic is synthesised.
- Routing and arbitration are identical in both builds.

Test Plan:
- Both arvalid held from reset with m_arready_i=1 → grants alternate s0,s1,s0,s1; m_arid_o MSB sequence 0,1,0,1; one AR every 2 cycles.
- Only s1 requests, m_arready_i low for 5 cycles → m_arvalid_o stays high with stable payload for 5 cycles; s1_arready_o seen high exactly once.
- s0 issues 4 ARs with no R returned (MAX_PENDING=4) → 5th AR is not granted; an s1 request is still served; after one rlast for port 0, s0 is granted on the next IDLE cycle.
- R burst arlen=3 with m_rid_i=5'b1_0011, s1_rready_i toggling → s1 sees 4 beats with rid=4'h3 and m_rready_o tracking s1_rready_i; s0_rvalid_o never asserts; pend1 decrements once at rlast.
- reset pulsed while in HOLD with pend0=2 → m_arvalid_o drops asynchronously; counters read 0; a later stray rlast for port 0 leaves pend0 at 0.
- AXI_RD_ARB_CHECK_EN defined: R beat for port 1 with pend1=0, or rresp=2'b10 → err_o=1 the next cycle and stays set; undefined build → err_o stays 0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin AR grant through one output register,
// R beats routed back by the ID MSB. Optional protocol checker: AXI_RD_ARB_CHECK_EN.
module axi_rd_arbiter #(
   parameter int ADDRS       = 27,
   parameter int WIDTH       = 32,
   parameter int REQID       = 4,
   parameter int MAX_PENDING = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               s0_arvalid_i,
   output logic               s0_arready_o,
   input  logic [ADDRS-1:0]   s0_araddr_i,
   input  logic [REQID-1:0]   s0_arid_i,
   input  logic [7:0]         s0_arlen_i,
   input  logic [1:0]         s0_arburst_i,
   output logic               s0_rvalid_o,
   input  logic               s0_rready_i,
   output logic               s0_rlast_o,
   output logic [1:0]         s0_rresp_o,
   output logic [REQID-1:0]   s0_rid_o,
   output logic [WIDTH-1:0]   s0_rdata_o,
   input  logic               s1_arvalid_i,
   output logic               s1_arready_o,
   input  logic [ADDRS-1:0]   s1_araddr_i,
   input  logic [REQID-1:0]   s1_arid_i,
   input  logic [7:0]         s1_arlen_i,
   input  logic [1:0]         s1_arburst_i,
   output logic               s1_rvalid_o,
   input  logic               s1_rready_i,
   output logic               s1_rlast_o,
   output logic [1:0]         s1_rresp_o,
   output logic [REQID-1:0]   s1_rid_o,
   output logic [WIDTH-1:0]   s1_rdata_o,
   output logic               m_arvalid_o,
   input  logic               m_arready_i,
   output logic [ADDRS-1:0]   m_araddr_o,
   output logic [REQID:0]     m_arid_o,
   output logic [7:0]         m_arlen_o,
   output logic [1:0]         m_arburst_o,
   input  logic               m_rvalid_i,
   output logic               m_rready_o,
   input  logic               m_rlast_i,
   input  logic [1:0]         m_rresp_i,
   input  logic [REQID:0]     m_rid_i,
   input  logic [WIDTH-1:0]   m_rdata_i,
   output logic               err_o
);

   localparam int CW = $clog2(MAX_PENDING + 1);
   localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PENDING);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic [CW-1:0]     pend0_q, pend0_d;
   logic [CW-1:0]     pend1_q, pend1_d;
   logic              arvalid_q, arvalid_d;
   logic [ADDRS-1:0]  araddr_q, araddr_d;
   logic [REQID:0]    arid_q, arid_d;
   logic [7:0]        arlen_q, arlen_d;
   logic [1:0]        arburst_q, arburst_d;

   logic elig0, elig1, gnt_vld, gnt_idx;
   logic sel, r_acc, r_done, dec0, dec1;

   // Count update: increment and decrement in one cycle cancel out.
   function automatic logic [CW-1:0] step_cnt(input logic [CW-1:0] cnt,
                                              input logic inc, input logic dec);
      logic [CW-1:0] res;
      res = cnt;
      if (inc && !dec) res = cnt + CW'(1);
      else if (dec && !inc) res = cnt - CW'(1);
      return res;
   endfunction

   assign elig0   = s0_arvalid_i && (pend0_q < PEND_MAX);
   assign elig1   = s1_arvalid_i && (pend1_q < PEND_MAX);
   assign gnt_vld = (state_q == IDLE) && (elig0 || elig1);
   assign gnt_idx = (elig0 && elig1) ? ptr_q : elig1;

   assign s0_arready_o = gnt_vld && !gnt_idx;
   assign s1_arready_o = gnt_vld && gnt_idx;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arid_d    = arid_q;
      arlen_d   = arlen_q;
      arburst_d = arburst_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d   = HOLD;
               arvalid_d = 1'b1;
               ptr_d     = ~gnt_idx;
               if (gnt_idx) begin
                  araddr_d  = s1_araddr_i;
                  arid_d    = {1'b1, s1_arid_i};
                  arlen_d   = s1_arlen_i;
                  arburst_d = s1_arburst_i;
               end else begin
                  araddr_d  = s0_araddr_i;
                  arid_d    = {1'b0, s0_arid_i};
                  arlen_d   = s0_arlen_i;
                  arburst_d = s0_arburst_i;
               end
            end
         end
         HOLD: begin
            if (arvalid_q && m_arready_i) begin
               arvalid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // R path is pure steering; the ID MSB selects the owning requester.
   assign sel         = m_rid_i[REQID];
   assign s0_rvalid_o = m_rvalid_i && !sel;
   assign s1_rvalid_o = m_rvalid_i && sel;
   assign m_rready_o  = sel ? s1_rready_i : s0_rready_i;
   assign s0_rlast_o  = m_rlast_i;
   assign s1_rlast_o  = m_rlast_i;
   assign s0_rresp_o  = m_rresp_i;
   assign s1_rresp_o  = m_rresp_i;
   assign s0_rid_o    = m_rid_i[REQID-1:0];
   assign s1_rid_o    = m_rid_i[REQID-1:0];
   assign s0_rdata_o  = m_rdata_i;
   assign s1_rdata_o  = m_rdata_i;

   assign r_acc  = m_rvalid_i && m_rready_o;
   assign r_done = r_acc && m_rlast_i;
   assign dec0   = r_done && !sel && (pend0_q != '0);
   assign dec1   = r_done && sel && (pend1_q != '0);

   always_comb begin
      pend0_d = step_cnt(pend0_q, s0_arready_o, dec0);
      pend1_d = step_cnt(pend1_q, s1_arready_o, dec1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b0;
         pend0_q   <= '0;
         pend1_q   <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arid_q    <= '0;
         arlen_q   <= '0;
         arburst_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         pend0_q   <= pend0_d;
         pend1_q   <= pend1_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arid_q    <= arid_d;
         arlen_q   <= arlen_d;
         arburst_q <= arburst_d;
      end
   end

   assign m_arvalid_o = arvalid_q;
   assign m_araddr_o  = araddr_q;
   assign m_arid_o    = arid_q;
   assign m_arlen_o   = arlen_q;
   assign m_arburst_o = arburst_q;

`ifdef AXI_RD_ARB_CHECK_EN
   logic err_q, err_d;
   logic pend_sel_zero;

   // An accepted beat with no burst outstanding, or any error response, is sticky.
   always_comb begin
      pend_sel_zero = sel ? (pend1_q == '0) : (pend0_q == '0);
      err_d = err_q || (r_acc && (pend_sel_zero || (m_rresp_i != 2'b00)));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
